vec_rr_packet_arbiter: RTL and testbench
========================================

// Module: vec_rr_packet_arbiter
// PURPOSE
//   Round-robin arbiter that shares one val/rdy message channel, such as the input of a shared
//   vector-lane queue, among NUM_REQ requesters. Arbitration is packet-granular: once a requester
//   wins, the grant stays locked to it until its beat flagged "last" is accepted. Accepted beats
//   pass through a 1-deep output register, tagged with the winning requester index.
// PARAMETERS
//   WIDTH    8   message width in bits
//   NUM_REQ  4   number of requesters (>=2)
//   ID_W     $clog2(NUM_REQ)  width of requester tag (derived; not overridden)
// PORTS
//   clk        in   1              clock; all state updates on posedge
//   reset      in   1              synchronous, active-high reset
//   recv_msg   in   NUM_REQ*WIDTH  requester i message at [i*WIDTH +: WIDTH]
//   recv_last  in   NUM_REQ        bit i: current beat of requester i ends its packet
//   recv_val   in   NUM_REQ        bit i: requester i beat valid
//   recv_rdy   out  NUM_REQ        bit i: arbiter accepts requester i beat this cycle
//   send_msg   out  WIDTH          registered message
//   send_id    out  ID_W           index of requester that produced send_msg
//   send_last  out  1              registered last flag
//   send_val   out  1              output register holds a beat
//   send_rdy   in   1              downstream accepts beat
// BEHAVIOUR
//   - One clock, synchronous active-high reset.
//   - Reset: send_val=0, send_msg/send_id/send_last=0, state=IDLE, rr_ptr=0, lock_id=0. recv_rdy=0
//     during the reset cycle. Reset mid-packet discards the lock and any held beat, with no flush.
//   - out_free = !send_val || send_rdy. Beat i is accepted iff recv_val[i] && recv_rdy[i].
//   - State IDLE: grant = first i with recv_val[i], searching i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     recv_rdy[grant] = out_free; all other recv_rdy bits are 0. If no requester is valid, all
//     recv_rdy=0. recv_rdy combinationally depends on recv_val; requesters must not make recv_val
//     depend on recv_rdy.
//   - IDLE accept, last=0: go to LOCKED, lock_id <= grant. IDLE accept, last=1: stay IDLE,
//     rr_ptr <= grant+1 (NUM_REQ-1 wraps to 0).
//   - State LOCKED: recv_rdy[lock_id] = out_free; all others are 0 regardless of their recv_val.
//     Accept with last=1: go to IDLE, rr_ptr <= lock_id+1 (wraps). Accept with last=0: stay LOCKED.
//   - Without an accept, rr_ptr and state hold. Idle cycles inside a locked packet keep the lock.
//   - Output register: on accept, load send_msg/send_id/send_last from the winner and set send_val=1
//     on the next edge. Else if send_rdy, clear send_val=0. Else hold all outputs stable.
//   - Latency: accept at edge N gives send_val high from N+1. Throughput is 1 beat/cycle when
//     send_rdy is held high (simultaneous drain and refill in the same cycle).
//   - Backpressure: send_rdy=0 with send_val=1 forces out_free=0, so all recv_rdy=0. No beat is
//     dropped or duplicated.
//   - Fairness: a requester that stays valid is granted within NUM_REQ-1 packets of other requesters.
//   - Beat order from one requester is preserved. Packets from different requesters never interleave.
// TESTING
//   1. Reset then idle: all recv_val=0 -> recv_rdy=0, send_val=0 for 10 cycles.
//   2. Single beat: req2 msg=0xA5 last=1, send_rdy=1 -> next cycle send_val=1, send_msg=0xA5,
//      send_id=2, send_last=1. rr_ptr becomes 3.
//   3. Round-robin: all 4 requesters valid with single-beat packets, send_rdy=1 -> send_id sequence
//      0,1,2,3,0,1 with no gap cycles.
//   4. Lock: req1 sends 3 beats (0x10,0x11,0x12 last) while req0 and req3 are valid -> outputs
//      0x10,0x11,0x12 with id=1 back-to-back, then next grant goes to req3 (rr_ptr=2).
//   5. Backpressure: send_rdy=0 for 5 cycles mid-packet -> send_msg stable, recv_rdy all 0, no loss.
//      Release send_rdy=1 -> packet resumes in order.
//   6. Reset mid-packet: assert reset while LOCKED on req2 with send_val=1 -> next cycle send_val=0,
//      state IDLE. A fresh req0 beat is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/vec_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_REQ val/rdy requesters share one channel
// through a 1-deep output register that tags each beat with the winning requester.
module vec_rr_packet_arbiter #(
    parameter  int WIDTH   = 8,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ*WIDTH-1:0] recv_msg,
    input  logic [NUM_REQ-1:0]       recv_last,
    input  logic [NUM_REQ-1:0]       recv_val,
    output logic [NUM_REQ-1:0]       recv_rdy,
    output logic [WIDTH-1:0]         send_msg,
    output logic [ID_W-1:0]          send_id,
    output logic                     send_last,
    output logic                     send_val,
    input  logic                     send_rdy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [ID_W-1:0] rr_ptr, rr_ptr_next;
    logic [ID_W-1:0] lock_id, lock_id_next;

    logic            out_free;
    logic            grant_found;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] win_id;
    logic [WIDTH-1:0] win_msg;
    logic            win_last;
    logic            accept;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1)
            return '0;
        else
            return id + ID_W'(1);
    endfunction

    assign out_free = !send_val || send_rdy;

    // Search starts at rr_ptr so the most recent winner is considered last.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && recv_val[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant       = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        win_id   = (state == LOCKED) ? lock_id : grant;
        win_msg  = recv_msg[int'(win_id)*WIDTH +: WIDTH];
        win_last = recv_last[win_id];
        recv_rdy = '0;
        if (!reset) begin
            if (state == LOCKED)
                recv_rdy[lock_id] = out_free;
            else if (grant_found)
                recv_rdy[grant] = out_free;
        end
    end

    assign accept = |(recv_val & recv_rdy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_next;
            rr_ptr  <= rr_ptr_next;
            lock_id <= lock_id_next;
        end
    end

    always_comb begin
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        lock_id_next = lock_id;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (win_last) begin
                        rr_ptr_next = next_id(grant);
                    end else begin
                        state_next   = LOCKED;
                        lock_id_next = grant;
                    end
                end
                LOCKED: begin
                    if (win_last) begin
                        state_next  = IDLE;
                        rr_ptr_next = next_id(lock_id);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output register: refill wins over drain, so a full register streams at one beat per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_val  <= 1'b0;
            send_msg  <= '0;
            send_id   <= '0;
            send_last <= 1'b0;
        end else if (accept) begin
            send_val  <= 1'b1;
            send_msg  <= win_msg;
            send_id   <= win_id;
            send_last <= win_last;
        end else if (send_rdy) begin
            send_val  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_rr_packet_arbiter.sv
// Directed bench for vec_rr_packet_arbiter (WIDTH=8, NUM_REQ=4) with hand-computed expectations.
module tb_vec_rr_packet_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ*WIDTH-1:0] recv_msg;
    logic [NUM_REQ-1:0]       recv_last;
    logic [NUM_REQ-1:0]       recv_val;
    logic [NUM_REQ-1:0]       recv_rdy;
    logic [WIDTH-1:0]         send_msg;
    logic [ID_W-1:0]          send_id;
    logic                     send_last;
    logic                     send_val;
    logic                     send_rdy;

    int checks = 0;
    int errors = 0;

    vec_rr_packet_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_last (recv_last),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_id   (send_id),
        .send_last (send_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] msg, input logic [1:0] id,
                             input logic last);
        check({tag, "_val"}, 32'(send_val), 32'd1);
        check({tag, "_msg"}, 32'(send_msg), 32'(msg));
        check({tag, "_id"}, 32'(send_id), 32'(id));
        check({tag, "_last"}, 32'(send_last), 32'(last));
    endtask

    initial begin
        // 1: reset then idle
        reset     = 1'b1;
        recv_val  = 4'hF;
        recv_last = 4'h0;
        recv_msg  = '0;
        send_rdy  = 1'b0;
        #1;
        check("rst_rdy", 32'(recv_rdy), 32'h0);
        step();
        check("rst_send_val", 32'(send_val), 32'd0);
        check("rst_send_msg", 32'(send_msg), 32'd0);
        check("rst_send_id", 32'(send_id), 32'd0);
        check("rst_send_last", 32'(send_last), 32'd0);
        reset    = 1'b0;
        recv_val = 4'h0;
        send_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("idle_rdy", 32'(recv_rdy), 32'h0);
            check("idle_send_val", 32'(send_val), 32'd0);
            step();
        end

        // 2: single beat from req2, rr_ptr then points at req3
        recv_msg[2*WIDTH +: WIDTH] = 8'hA5;
        recv_last = 4'b0100;
        recv_val  = 4'b0100;
        #1;
        check("single_rdy", 32'(recv_rdy), 32'b0100);
        step();
        check_out("single", 8'hA5, 2'd2, 1'b1);
        recv_val = 4'hF;
        #1;
        check("rrptr3_rdy", 32'(recv_rdy), 32'b1000);
        recv_val = 4'h0;
        step();
        check("drain_send_val", 32'(send_val), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // 3: round robin over single-beat packets with no gap cycles
        for (int i = 0; i < NUM_REQ; i++) recv_msg[i*WIDTH +: WIDTH] = 8'(8'h30 + i);
        recv_last = 4'hF;
        recv_val  = 4'hF;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr_rdy", 32'(recv_rdy), 32'(1 << (n % 4)));
            step();
            check_out("rr", 8'(8'h30 + (n % 4)), 2'(n % 4), 1'b1);
        end
        recv_val = 4'h0;
        step();

        // 4: move rr_ptr to 1, then a 3-beat packet from req1 while req0/req3 wait
        recv_msg[0*WIDTH +: WIDTH] = 8'h01;
        recv_last = 4'b0001;
        recv_val  = 4'b0001;
        step();
        check_out("pre", 8'h01, 2'd0, 1'b1);
        recv_msg[1*WIDTH +: WIDTH] = 8'h10;
        recv_msg[3*WIDTH +: WIDTH] = 8'h70;
        recv_last = 4'b1001;
        recv_val  = 4'b1011;
        #1;
        check("lock_rdy0", 32'(recv_rdy), 32'b0010);
        step();
        check_out("lock0", 8'h10, 2'd1, 1'b0);
        recv_msg[1*WIDTH +: WIDTH] = 8'h11;
        #1;
        check("lock_rdy1", 32'(recv_rdy), 32'b0010);
        step();
        check_out("lock1", 8'h11, 2'd1, 1'b0);
        recv_msg[1*WIDTH +: WIDTH] = 8'h12;
        recv_last = 4'b1011;
        step();
        check_out("lock2", 8'h12, 2'd1, 1'b1);
        recv_val = 4'b1001;
        #1;
        check("after_lock_rdy", 32'(recv_rdy), 32'b1000);

        // 5: backpressure in the middle of a req3 packet
        recv_last = 4'b0001;
        step();
        check_out("bp0", 8'h70, 2'd3, 1'b0);
        recv_msg[3*WIDTH +: WIDTH] = 8'h71;
        send_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rdy", 32'(recv_rdy), 32'h0);
            step();
            check_out("bp_hold", 8'h70, 2'd3, 1'b0);
        end
        send_rdy = 1'b1;
        #1;
        check("bp_release_rdy", 32'(recv_rdy), 32'b1000);
        step();
        check_out("bp1", 8'h71, 2'd3, 1'b0);
        recv_msg[3*WIDTH +: WIDTH] = 8'h72;
        recv_last = 4'b1001;
        step();
        check_out("bp2", 8'h72, 2'd3, 1'b1);
        #1;
        check("after_bp_rdy", 32'(recv_rdy), 32'b0001);
        recv_val = 4'h0;
        step();
        check("bp_drain_val", 32'(send_val), 32'd0);

        // 6: reset while locked on req2 with a held beat
        recv_msg[2*WIDTH +: WIDTH] = 8'h40;
        recv_last = 4'b0000;
        recv_val  = 4'b0100;
        step();
        check_out("mid0", 8'h40, 2'd2, 1'b0);
        send_rdy = 1'b0;
        reset    = 1'b1;
        recv_msg[0*WIDTH +: WIDTH] = 8'h55;
        recv_last = 4'b0001;
        recv_val  = 4'b0101;
        #1;
        check("midrst_rdy", 32'(recv_rdy), 32'h0);
        step();
        check("midrst_send_val", 32'(send_val), 32'd0);
        check("midrst_send_msg", 32'(send_msg), 32'd0);
        check("midrst_send_id", 32'(send_id), 32'd0);
        reset    = 1'b0;
        send_rdy = 1'b1;
        #1;
        check("postrst_rdy", 32'(recv_rdy), 32'b0001);
        step();
        check_out("postrst", 8'h55, 2'd0, 1'b1);
        recv_val = 4'h0;
        step();
        check("final_send_val", 32'(send_val), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
